// File: rtl/m_cp0_pkg.sv
// CP0 register numbers, ExcCodes and SR/Cause field positions shared by the M-stage exception logic.
package m_cp0_pkg;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_BD    = 31;

    // Restart address: a delay-slot fault must re-execute the branch, and EPC is always word aligned.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] t;
        t = bd ? pc - 32'd4 : pc;
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/m_cp0.sv
// M-stage CP0: SR/Cause/EPC/PRId, flush request, eret target.
// Latency: dout/req/epc_out combinational, state on next edge; no backpressure.
module m_cp0
    import m_cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2024_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        exc_m,
    input  logic [4:0]  exc_code_m,
    input  logic [5:0]  hw_int,
    input  logic        eret_m,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    assign exc_req = exc_m & ~exl_q;
    assign req     = int_req | exc_req;

    assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b0};

    assign handler_pc = HANDLER_PC;
    assign epc_out    = (we && addr == CP0_EPC) ? din : epc_q;

    always_comb begin
        dout = 32'b0;
        case (addr)
            CP0_SR:    dout = sr_val;
            CP0_CAUSE: dout = cause_val;
            CP0_EPC:   dout = epc_q;
            CP0_PRID:  dout = PRID_VALUE;
            default:   dout = 32'b0;
        endcase
    end

    // A taken request flushes the M instruction, so its eret/mtc0 must not land.
    always_comb begin
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        ip_d   = hw_int;
        if (req) begin
            exl_d  = 1'b1;
            code_d = int_req ? EXC_INT : exc_code_m;
            bd_d   = bd_m;
            epc_d  = epc_of(pc_m, bd_m);
        end else if (eret_m) begin
            exl_d = 1'b0;
        end else if (we) begin
            case (addr)
                CP0_SR: begin
                    im_d  = din[SR_IM_LO +: 6];
                    exl_d = din[SR_EXL];
                    ie_d  = din[SR_IE];
                end
                CP0_EPC: epc_d = din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q   <= '0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= '0;
            code_q <= '0;
            epc_q  <= '0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= ip_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

endmodule

// File: tb/tb_m_cp0.sv
// Directed scoreboard bench for m_cp0: stimulus queues expectations, monitor compares outputs.
module tb_m_cp0;
    import m_cp0_pkg::*;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        exc_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic        eret_m;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    m_cp0 dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .pc_m       (pc_m),
        .bd_m       (bd_m),
        .exc_m      (exc_m),
        .exc_code_m (exc_code_m),
        .hw_int     (hw_int),
        .eret_m     (eret_m),
        .req        (req),
        .handler_pc (handler_pc),
        .epc_out    (epc_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          sel_q[$];
    logic [31:0] exp_q[$];
    string       nm_q[$];
    event        chk_ev;

    // Monitor: drains every queued expectation against the live outputs.
    initial begin
        forever begin
            @(chk_ev);
            while (sel_q.size() > 0) begin
                int          s;
                logic [31:0] e;
                logic [31:0] a;
                string       n;
                s = sel_q.pop_front();
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                case (s)
                    0:       a = dout;
                    1:       a = {31'b0, req};
                    2:       a = epc_out;
                    default: a = handler_pc;
                endcase
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, a, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic push_exp(input int s, input logic [31:0] e, input string n);
        #1;
        sel_q.push_back(s);
        exp_q.push_back(e);
        nm_q.push_back(n);
        ->chk_ev;
        #1;
    endtask

    task automatic exp_reg(input logic [4:0] a, input logic [31:0] e, input string n);
        addr = a;
        push_exp(0, e, n);
    endtask

    task automatic exp_req(input logic e, input string n);
        push_exp(1, {31'b0, e}, n);
    endtask

    task automatic exp_epco(input logic [31:0] e, input string n);
        push_exp(2, e, n);
    endtask

    task automatic tick;
        @(posedge clk);
        #5;
    endtask

    task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic bd);
        exc_m = 1'b1;
        exc_code_m = code;
        pc_m = pc;
        bd_m = bd;
    endtask

    task automatic clear_m;
        exc_m = 1'b0;
        we = 1'b0;
        eret_m = 1'b0;
        bd_m = 1'b0;
    endtask

    task automatic do_eret;
        eret_m = 1'b1;
        tick();
        eret_m = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        we = 1'b0;
        addr = '0;
        din = '0;
        pc_m = '0;
        bd_m = 1'b0;
        exc_m = 1'b0;
        exc_code_m = '0;
        hw_int = '0;
        eret_m = 1'b0;

        #20;
        exp_reg(CP0_PRID, 32'h2024_0007, "prid_in_reset");
        exp_reg(CP0_SR, 32'h0, "sr_in_reset");
        exp_req(1'b0, "req_in_reset_idle");
        exc_m = 1'b1;
        exp_req(1'b1, "req_in_reset_exc");
        exc_m = 1'b0;
        #60 reset = 1'b1;
        tick();

        exp_reg(CP0_SR, 32'h0, "reset_sr");
        exp_reg(CP0_CAUSE, 32'h0, "reset_cause");
        exp_reg(CP0_EPC, 32'h0, "reset_epc");
        exp_reg(CP0_PRID, 32'h2024_0007, "reset_prid");
        exp_reg(5'd3, 32'h0, "unmapped_reg");
        exp_req(1'b0, "reset_req");
        push_exp(3, 32'h0000_4180, "handler_pc");

        // Overflow, then a nested fault while EXL=1 must be ignored.
        raise(EXC_OV, 32'h3008, 1'b0);
        exp_req(1'b1, "ov_req_before");
        tick();
        exp_reg(CP0_CAUSE, 32'h0000_0030, "ov_cause");
        exp_reg(CP0_EPC, 32'h0000_3008, "ov_epc");
        exp_reg(CP0_SR, 32'h0000_0002, "ov_sr_exl");
        exp_req(1'b0, "ov_req_masked");
        raise(EXC_ADES, 32'h5000, 1'b1);
        tick();
        clear_m();
        exp_reg(CP0_CAUSE, 32'h0000_0030, "nested_cause");
        exp_reg(CP0_EPC, 32'h0000_3008, "nested_epc");
        do_eret();
        exp_reg(CP0_SR, 32'h0, "ov_eret_sr");

        raise(EXC_ADES, 32'h3010, 1'b1);
        exp_req(1'b1, "ades_req");
        tick();
        clear_m();
        exp_reg(CP0_EPC, 32'h0000_300C, "ades_epc");
        exp_reg(CP0_CAUSE, 32'h8000_0014, "ades_cause");
        do_eret();

        raise(EXC_ADEL, 32'h0, 1'b1);
        tick();
        clear_m();
        exp_reg(CP0_EPC, 32'hFFFF_FFFC, "wrap_epc");
        exp_reg(CP0_CAUSE, 32'h8000_0010, "wrap_cause");
        do_eret();

        // Interrupt path.
        we = 1'b1;
        addr = CP0_SR;
        din = 32'h0000_0401;
        tick();
        we = 1'b0;
        exp_reg(CP0_SR, 32'h0000_0401, "sr_write");
        exp_req(1'b0, "int_req_idle");
        hw_int = 6'b000001;
        pc_m = 32'h3020;
        exp_req(1'b1, "int_req");
        tick();
        hw_int = 6'b0;
        exp_reg(CP0_CAUSE, 32'h0000_0400, "int_cause");
        exp_reg(CP0_EPC, 32'h0000_3020, "int_epc");
        exp_reg(CP0_SR, 32'h0000_0403, "int_sr");
        do_eret();
        exp_reg(CP0_SR, 32'h0000_0401, "int_eret_sr");
        exp_reg(CP0_CAUSE, 32'h0, "int_ip_cleared");

        hw_int = 6'b000001;
        raise(EXC_RI, 32'h3030, 1'b0);
        exp_req(1'b1, "int_exc_req");
        tick();
        clear_m();
        hw_int = 6'b0;
        exp_reg(CP0_CAUSE, 32'h0000_0400, "int_wins_cause");
        exp_reg(CP0_EPC, 32'h0000_3030, "int_wins_epc");
        do_eret();

        // Field masking: SR keeps only IM/EXL/IE, Cause writes dropped.
        we = 1'b1;
        addr = CP0_SR;
        din = 32'hFFFF_FFFF;
        tick();
        addr = CP0_CAUSE;
        tick();
        addr = CP0_SR;
        din = 32'h0;
        exp_reg(CP0_CAUSE, 32'h0, "cause_write_dropped");
        addr = CP0_SR;
        tick();
        we = 1'b0;
        exp_reg(CP0_SR, 32'h0, "sr_cleared");

        // Exception beats a same-cycle mtc0 EPC.
        raise(EXC_OV, 32'h3040, 1'b0);
        we = 1'b1;
        addr = CP0_EPC;
        din = 32'hDEAD_BEEC;
        exp_epco(32'hDEAD_BEEC, "bypass_with_req");
        exp_req(1'b1, "prio_req");
        tick();
        clear_m();
        exp_reg(CP0_EPC, 32'h0000_3040, "prio_epc");

        // Return with mtc0 EPC immediately before eret.
        we = 1'b1;
        addr = CP0_EPC;
        din = 32'h0000_3100;
        exp_epco(32'h0000_3100, "epc_bypass");
        exp_reg(CP0_EPC, 32'h0000_3040, "epc_reg_pre_write");
        tick();
        we = 1'b0;
        eret_m = 1'b1;
        exp_epco(32'h0000_3100, "eret_epc_out");
        tick();
        eret_m = 1'b0;
        exp_reg(CP0_SR, 32'h0, "eret_exl_clear");

        // Asynchronous reset mid-cycle.
        raise(EXC_OV, 32'h3008, 1'b0);
        tick();
        clear_m();
        exp_reg(CP0_SR, 32'h0000_0002, "pre_areset_sr");
        #20 reset = 1'b0;
        exp_reg(CP0_SR, 32'h0, "areset_sr");
        exp_reg(CP0_CAUSE, 32'h0, "areset_cause");
        exp_reg(CP0_EPC, 32'h0, "areset_epc");
        #10 reset = 1'b1;
        exp_reg(CP0_EPC, 32'h0, "post_release_epc");
        tick();
        exp_reg(CP0_SR, 32'h0, "post_release_sr");

        #5;
        if (sel_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sel_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_cp0.md
# m_cp0

Coprocessor-0 exception/interrupt controller for the P7 MIPS pipeline, placed in the M stage directly downstream of the E-stage ALU. It takes the exception flag and 5-bit ExcCode carried down the E/M register (Ov, AdEL, AdES, plus codes raised earlier such as RI and Syscall) and the six external hardware interrupt lines. It holds SR, Cause, EPC and PRId, serves `mfc0`/`mtc0`, raises the pipeline-flush request, and supplies the `eret` return address.

## Interface
Parameters:
- `PRID_VALUE`, default 32'h2024_0007: read-only PRId content.
- `HANDLER_PC`, default 32'h0000_4180: exception entry address driven on `handler_pc`.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `we` in 1: `mtc0` write strobe (M stage).
- `addr` in 5: CP0 register number for read and write.
- `din` in 32: `mtc0` write data.
- `dout` out 32: `mfc0` read data, combinational from `addr`.
- `pc_m` in 32: PC of the instruction in M.
- `bd_m` in 1: the M instruction sits in a branch delay slot.
- `exc_m` in 1: exception pending on the M instruction.
- `exc_code_m` in 5: ExcCode for `exc_m`.
- `hw_int` in 6: external interrupt lines, level-sensitive.
- `eret_m` in 1: `eret` in M.
- `req` out 1: combinational flush/redirect request.
- `handler_pc` out 32: equals `HANDLER_PC`.
- `epc_out` out 32: current EPC, with `mtc0` EPC write bypass.

## Operation
Register fields:
- SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0. Software writes are ignored.
- EPC (14): 32 bits, fully writable.
- PRId (15): constant.
- Any other `addr` reads 0.

Request logic:
- `int_req` = |(`hw_int` & IM) & IE & ~EXL.
- `exc_req` = `exc_m` & ~EXL.
- `req` = `int_req` | `exc_req`.
- Interrupt outranks exception when both are present.

On a rising edge with `req`:
- EXL ← 1.
- ExcCode ← 0 for an interrupt, otherwise `exc_code_m`.
- BD ← `bd_m`.
- EPC ← `bd_m` ? `pc_m`−4 : `pc_m`, word-aligned ({x[31:2],2'b00}).
- `we` and `eret_m` are ignored that cycle, because the M instruction is flushed.

On a rising edge with `eret_m` and no `req`: EXL ← 0.

On a rising edge with `we` and neither of the above:
- SR takes only the IM, EXL and IE bits.
- EPC is written fully.
- Writes to Cause and PRId are dropped.

IP ← `hw_int` on every edge, including `req` cycles.

Priority per edge: `req` > `eret_m` > `we`.

`epc_out` = (`we` && `addr`==14) ? `din` : EPC. This bypass covers `mtc0 EPC` immediately before `eret`.

## Timing
- Reset (asynchronous, active-low): SR, Cause and EPC go to 0.
  - `dout` follows `addr`; PRId still reads `PRID_VALUE`.
  - `req` reflects only `exc_m` (EXL=0).
- `dout`, `req` and `epc_out` are combinational, zero latency.
- Register updates take effect on the next rising edge.
- After a taken exception, EXL=1 masks further `req` until the edge after `eret_m`.
- `exc_m` while EXL=1: no request, no state change. Nested exceptions are not recorded.
- `hw_int` pulse shorter than one cycle: it is captured only if high at a clock edge or while `req` is evaluated.
- `reset` deasserted mid-cycle: state stays 0 until the next edge.
- `pc_m`−4 wraps modulo 2^32 (`pc_m`=0 gives EPC=32'hFFFF_FFFC).

## Structure
- Shared `parameters.v` holds:
  - ExcCodes: `Int`=0, `AdEL`=4, `AdES`=5, `Syscall`=8, `RI`=10, `Ov`=12.
  - CP0 register numbers `cp0_sr`=12, `cp0_cause`=13, `cp0_epc`=14, `cp0_prid`=15.
  - SR/Cause bit positions.
- Single module, no sub-module needed.
- The E/M pipeline register carries the ALU's `exception`/`exception_type` into `exc_m`/`exc_code_m`.

## Test plan
- Reset, then read `addr` 12/13/14/15: expect 0, 0, 0, 32'h2024_0007; `req`=0 with `exc_m`=0.
- Overflow: `exc_m`=1, `exc_code_m`=12, `pc_m`=32'h3008, `bd_m`=0, then one edge.
  - Expect `req`=1 before the edge.
  - After the edge: Cause=32'h0000_0030, EPC=32'h3008, SR.EXL=1, `req`=0.
- Delay-slot AdES: `exc_code_m`=5, `pc_m`=32'h3010, `bd_m`=1, then one edge.
  - Expect EPC=32'h300C, Cause=32'h8000_0014.
- Interrupt: `mtc0` SR=32'h0000_0401 on one edge, then `hw_int`=6'b000001 the next cycle.
  - Expect `req`=1 and ExcCode=0.
  - Same setup with simultaneous `exc_m` (code 10): ExcCode=0, because the interrupt wins.
- Return: `mtc0` EPC=32'h3100 with `eret_m` the next cycle.
  - Expect `epc_out`=32'h3100 in the `mtc0` cycle (bypass) and EXL=0 after the `eret` edge.
  - `exc_m` while EXL=1: no state change.
- Asynchronous reset asserted mid-cycle with EXL=1 and EPC=32'h3008.
  - Expect SR, Cause and EPC to read 0 before the next clock edge.
